// File: rtl/me_blt_ctl.sv
// me_blt_ctl: player bullet spawn/flight/cooldown FSM plus bullet sprite ROM address generator.
// Optional feature: define BLT_AUTOFIRE_EN to spawn on the fire level instead of its rising edge.
module me_blt_ctl #(
  parameter int          BLT_W       = 8,
  parameter int          BLT_H       = 16,
  parameter int          ME_W        = 32,
  parameter int          BLT_SPEED   = 4,
  parameter int          COOL_FRAMES = 10,
  parameter logic [16:0] BLT_BASE    = 17'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fire,
  input  logic        frame_tick,
  input  logic [9:0]  me_x,
  input  logic [9:0]  me_y,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  output logic [16:0] me_blt_addr,
  output logic        blt_active,
  output logic [9:0]  blt_x,
  output logic [9:0]  blt_y
);

  localparam int               CNT_W     = (COOL_FRAMES < 2) ? 1 : $clog2(COOL_FRAMES + 1);
  localparam logic [9:0]       X_OFS     = 10'(ME_W / 2 - BLT_W / 2);
  localparam logic [9:0]       BLT_H_V   = 10'(BLT_H);
  localparam logic [9:0]       SPEED_V   = 10'(BLT_SPEED);
  localparam logic [10:0]      BLT_W_E   = 11'(BLT_W);
  localparam logic [10:0]      BLT_H_E   = 11'(BLT_H);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [9:0]       blt_x_nxt, blt_y_nxt;
  logic             fire_d, fire_rise, spawn;
  logic             hit;
  logic [10:0]      h_e, v_e, x_e, y_e;
  logic [9:0]       row, col;
  logic [16:0]      addr_nxt;

  assign fire_rise = fire & ~fire_d;

`ifdef BLT_AUTOFIRE_EN
  assign spawn = fire;
`else
  assign spawn = fire_rise;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    blt_x_nxt = blt_x;
    blt_y_nxt = blt_y;
    case (state)
      IDLE: begin
        // Spawn wins over a coincident frame_tick: the bullet does not move on its first cycle.
        if (spawn) begin
          blt_x_nxt = me_x + X_OFS;
          blt_y_nxt = (me_y < BLT_H_V) ? 10'd0 : me_y - BLT_H_V;
          state_nxt = FLY;
        end
      end
      FLY: begin
        if (frame_tick) begin
          if (blt_y >= SPEED_V) begin
            blt_y_nxt = blt_y - SPEED_V;
          end else begin
            state_nxt = COOL;
            cnt_nxt   = COOL_LOAD;
          end
        end
      end
      COOL: begin
        if (frame_tick) begin
          if (cnt <= CNT_ONE) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Widened to 11 bits so a bullet near the right/bottom edge cannot wrap its far bound.
  assign h_e = {1'b0, h_cnt};
  assign v_e = {1'b0, v_cnt};
  assign x_e = {1'b0, blt_x};
  assign y_e = {1'b0, blt_y};
  assign hit = (state == FLY) && (h_e >= x_e) && (h_e < x_e + BLT_W_E) &&
               (v_e >= y_e) && (v_e < y_e + BLT_H_E);
  assign row = v_cnt - blt_y;
  assign col = h_cnt - blt_x;

  always_comb begin
    addr_nxt = 17'd0;
    if (hit) begin
      addr_nxt = BLT_BASE + 17'(row) * 17'(BLT_W) + 17'(col);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      fire_d      <= 1'b0;
      blt_x       <= 10'd0;
      blt_y       <= 10'd0;
      blt_active  <= 1'b0;
      me_blt_addr <= 17'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      fire_d      <= fire;
      blt_x       <= blt_x_nxt;
      blt_y       <= blt_y_nxt;
      blt_active  <= (state_nxt == FLY);
      me_blt_addr <= addr_nxt;
    end
  end

endmodule
